// File: rtl/sparc_data_ram_if.sv
// Request/response bus for sparc_data_ram: valid/ready request channel, and response
// beats that the memory pushes to the requester.
interface sparc_data_ram_if #(
   parameter int ADDR_WIDTH = 9
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  read_write;
   logic [1:0]            size;
   logic                  sign_ext;
   logic [ADDR_WIDTH-1:0] addr;
   logic [63:0]           wdata;
   logic                  resp_valid;
   logic                  resp_last;
   logic [31:0]           rdata;
   logic                  misaligned;

   modport master (
      output req_valid, read_write, size, sign_ext, addr, wdata,
      input  req_ready, resp_valid, resp_last, rdata, misaligned
   );

   modport slave (
      input  req_valid, read_write, size, sign_ext, addr, wdata,
      output req_ready, resp_valid, resp_last, rdata, misaligned
   );
endinterface

// File: rtl/sparc_data_ram.sv
// Big-endian byte-addressed data memory for the SPARC MEM stage with byte/half/word/dword
// loads and stores, programmable access latency and misalignment reporting.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | latency countdown before the first beat
// BEAT1 | first (or only) response beat; stores commit at the edge leaving it
// BEAT2 | second word of a dword load
// ERR   | misaligned request rejected, single error beat
module sparc_data_ram #(
   parameter int ADDR_WIDTH = 9,
   parameter int LATENCY    = 1
) (
   input logic            clk,
   input logic            reset,
   sparc_data_ram_if.slave bus
);
   localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
   localparam int WW    = ADDR_WIDTH - 2;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [2:0] {IDLE, WAIT, BEAT1, BEAT2, ERR} state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic                  rw_q, sext_q;
   logic [1:0]            size_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [63:0]           wdata_q;
   logic                  resp_valid_q, resp_last_q, mis_q;
   logic [31:0]           rdata_q;

   logic [31:0] Mem [0:DEPTH-1];

   logic                  src_rw, src_sext, beat_last, misal;
   logic [1:0]            src_size;
   logic [ADDR_WIDTH-1:0] src_addr;
   logic [31:0]           src_word, lane_sh, beat_rdata;
   logic [15:0]           half_sel;
   logic [4:0]            shamt, st_shamt;
   logic [WW-1:0]         w_q, w1_q;
   logic [31:0]           st_mask, st_data, st_word;

   // With LATENCY==1 the first beat is built straight from the live request,
   // otherwise from the fields captured at acceptance.
   always_comb begin
      src_rw     = (state_q == IDLE) ? bus.read_write : rw_q;
      src_sext   = (state_q == IDLE) ? bus.sign_ext   : sext_q;
      src_size   = (state_q == IDLE) ? bus.size       : size_q;
      src_addr   = (state_q == IDLE) ? bus.addr       : addr_q;
      src_word   = Mem[src_addr[ADDR_WIDTH-1:2]];
      shamt      = {~src_addr[1:0], 3'b000};
      lane_sh    = src_word >> shamt;
      half_sel   = src_addr[1] ? src_word[15:0] : src_word[31:16];
      beat_rdata = '0;
      if (src_rw) begin
         case (src_size)
            2'b00:   beat_rdata = src_sext ? {{24{lane_sh[7]}}, lane_sh[7:0]} : {24'h0, lane_sh[7:0]};
            2'b01:   beat_rdata = src_sext ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            default: beat_rdata = src_word;
         endcase
      end
      beat_last = !(src_rw && (src_size == 2'b11));

      case (bus.size)
         2'b01:   misal = bus.addr[0];
         2'b10:   misal = |bus.addr[1:0];
         2'b11:   misal = |bus.addr[2:0];
         default: misal = 1'b0;
      endcase
   end

   always_comb begin
      w_q      = addr_q[ADDR_WIDTH-1:2];
      w1_q     = {w_q[WW-1:1], 1'b1};
      st_shamt = {~addr_q[1:0], 3'b000};
      case (size_q)
         2'b00: begin
            st_mask = 32'h0000_00FF << st_shamt;
            st_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            st_mask = addr_q[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
            st_data = {2{wdata_q[15:0]}};
         end
         2'b10: begin
            st_mask = 32'hFFFF_FFFF;
            st_data = wdata_q[31:0];
         end
         default: begin
            st_mask = 32'hFFFF_FFFF;
            st_data = wdata_q[63:32];
         end
      endcase
      st_word = (Mem[w_q] & ~st_mask) | (st_data & st_mask);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_last_q  <= 1'b0;
         rdata_q      <= '0;
         mis_q        <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_last_q  <= 1'b0;
         rdata_q      <= '0;
         mis_q        <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  rw_q    <= bus.read_write;
                  size_q  <= bus.size;
                  sext_q  <= bus.sign_ext;
                  addr_q  <= bus.addr;
                  wdata_q <= bus.wdata;
                  if (misal) begin
                     state_q      <= ERR;
                     resp_valid_q <= 1'b1;
                     resp_last_q  <= 1'b1;
                     mis_q        <= 1'b1;
                  end else if (LATENCY == 1) begin
                     state_q      <= BEAT1;
                     resp_valid_q <= 1'b1;
                     resp_last_q  <= beat_last;
                     rdata_q      <= beat_rdata;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 4'd1) begin
                  state_q      <= BEAT1;
                  cnt_q        <= '0;
                  resp_valid_q <= 1'b1;
                  resp_last_q  <= beat_last;
                  rdata_q      <= beat_rdata;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            BEAT1: begin
               if (!rw_q) begin
                  Mem[w_q] <= st_word;
                  if (size_q == 2'b11) Mem[w1_q] <= wdata_q[31:0];
               end
               if (rw_q && (size_q == 2'b11)) begin
                  state_q      <= BEAT2;
                  resp_valid_q <= 1'b1;
                  resp_last_q  <= 1'b1;
                  rdata_q      <= Mem[w1_q];
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state_q == IDLE) && !reset;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_last  = resp_last_q;
   assign bus.rdata      = rdata_q;
   assign bus.misaligned = mis_q;
endmodule

// File: tb/tb_sparc_data_ram.sv
// Bench for sparc_data_ram: three instances (LATENCY 1, 3, 4) share stimulus; a
// byte-array memory model supplies expected load data and beat timing.
module tb_sparc_data_ram;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int sel   = 0;

   logic        req_valid, read_write, sign_ext;
   logic [1:0]  size;
   logic [8:0]  addr;
   logic [63:0] wdata;
   logic        req_ready, resp_valid, resp_last, misaligned;
   logic [31:0] rdata;

   logic [7:0] mb [3][512];

   sparc_data_ram_if #(.ADDR_WIDTH(9)) if1 ();
   sparc_data_ram_if #(.ADDR_WIDTH(9)) if3 ();
   sparc_data_ram_if #(.ADDR_WIDTH(9)) if4 ();

   sparc_data_ram #(.ADDR_WIDTH(9), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   sparc_data_ram #(.ADDR_WIDTH(9), .LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));
   sparc_data_ram #(.ADDR_WIDTH(9), .LATENCY(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

   assign if1.req_valid = req_valid && (sel == 0);
   assign if3.req_valid = req_valid && (sel == 1);
   assign if4.req_valid = req_valid && (sel == 2);
   assign if1.read_write = read_write;
   assign if3.read_write = read_write;
   assign if4.read_write = read_write;
   assign if1.size = size;
   assign if3.size = size;
   assign if4.size = size;
   assign if1.sign_ext = sign_ext;
   assign if3.sign_ext = sign_ext;
   assign if4.sign_ext = sign_ext;
   assign if1.addr = addr;
   assign if3.addr = addr;
   assign if4.addr = addr;
   assign if1.wdata = wdata;
   assign if3.wdata = wdata;
   assign if4.wdata = wdata;

   always_comb begin
      case (sel)
         0: begin
            req_ready = if1.req_ready; resp_valid = if1.resp_valid; resp_last = if1.resp_last;
            rdata = if1.rdata; misaligned = if1.misaligned;
         end
         1: begin
            req_ready = if3.req_ready; resp_valid = if3.resp_valid; resp_last = if3.resp_last;
            rdata = if3.rdata; misaligned = if3.misaligned;
         end
         default: begin
            req_ready = if4.req_ready; resp_valid = if4.resp_valid; resp_last = if4.resp_last;
            rdata = if4.rdata; misaligned = if4.misaligned;
         end
      endcase
   end

   function automatic int lat_of(input int s);
      return (s == 0) ? 1 : (s == 1) ? 3 : 4;
   endfunction

   function automatic int nbytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

   function automatic logic [31:0] mword(input int s, input int a);
      return {mb[s][a], mb[s][a+1], mb[s][a+2], mb[s][a+3]};
   endfunction

   function automatic logic [31:0] exp_load(input int s, input logic [1:0] sz, input logic sx, input int a);
      logic [7:0]  b;
      logic [15:0] h;
      case (sz)
         2'b00: begin
            b = mb[s][a];
            return (sx && b[7]) ? {24'hFF_FFFF, b} : {24'h0, b};
         end
         2'b01: begin
            h = {mb[s][a], mb[s][a+1]};
            return (sx && h[15]) ? {16'hFFFF, h} : {16'h0, h};
         end
         default: return mword(s, a);
      endcase
   endfunction

   task automatic model_store(input int s, input logic [1:0] sz, input int a, input logic [63:0] wd);
      int n;
      n = nbytes(sz);
      for (int i = 0; i < n; i++) mb[s][a+i] = wd[8*(n-1-i) +: 8];
   endtask

   task automatic preload(input int s, input int w, input logic [31:0] v);
      case (s)
         0:       dut1.Mem[w] = v;
         1:       dut3.Mem[w] = v;
         default: dut4.Mem[w] = v;
      endcase
      for (int i = 0; i < 4; i++) mb[s][4*w+i] = v[31-8*i -: 8];
   endtask

   // One request on the selected instance; reports beats by offset from the acceptance edge.
   task automatic do_access(input logic rw, input logic [1:0] sz, input logic sx, input logic [8:0] a,
                            input logic [63:0] wd, output int nb, output int off0, output int off1,
                            output logic [31:0] rd0, output logic [31:0] rd1, output logic l0,
                            output logic l1, output logic m0, output logic rdy_ok, output logic tmo);
      int last_off;
      nb = 0; off0 = 0; off1 = 0; rd0 = '0; rd1 = '0; l0 = 0; l1 = 0; m0 = 0;
      rdy_ok = 1; tmo = 0; last_off = -1;
      @(negedge clk);
      read_write = rw; size = sz; sign_ext = sx; addr = a; wdata = wd; req_valid = 1'b1;
      #1;
      if (!req_ready) rdy_ok = 0;
      @(posedge clk);
      #1;
      req_valid = 1'b0; read_write = 1'($urandom); size = 2'($urandom);
      addr = 9'($urandom); wdata = {$urandom, $urandom};
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (last_off >= 0) begin
            if (!req_ready) rdy_ok = 0;
            if (resp_valid) nb++;
            break;
         end
         if (req_ready) rdy_ok = 0;
         if (resp_valid) begin
            if (nb == 0) begin
               off0 = k; rd0 = rdata; l0 = resp_last; m0 = misaligned;
            end else begin
               off1 = k; rd1 = rdata; l1 = resp_last;
            end
            nb++;
            if (resp_last) last_off = k;
         end
      end
      if (last_off < 0) tmo = 1;
   endtask

   int          nb, off0, off1;
   logic [31:0] rd0, rd1;
   logic        l0, l1, m0, rdy_ok, tmo;

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         total++;
         if (req_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready_in_reset inst%0d: got %b want 0", s, req_ready);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         total++;
         if ({req_ready, resp_valid, resp_last, misaligned, rdata} !== {4'b1000, 32'h0}) begin
            bad++;
            $display("FAIL reset_outputs inst%0d: got rdy=%b v=%b l=%b m=%b d=%h want 1 0 0 0 0",
                     s, req_ready, resp_valid, resp_last, misaligned, rdata);
         end
      end
      sel = 0;
   endtask

   task automatic test_subword_loads();
      logic [1:0]  szs [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
      logic        sxs [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [8:0]  as  [4] = '{9'd3, 9'd1, 9'd0, 9'd2};
      logic [31:0] exs [4] = '{32'hFFFF_FFF6, 32'h0000_0012, 32'hFFFF_8012, 32'h0000_34F6};
      sel = 0;
      preload(0, 0, 32'h8012_34F6);
      for (int i = 0; i < 4; i++) begin
         do_access(1'b1, szs[i], sxs[i], as[i], 64'h0, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
         total++;
         if (rd0 !== exs[i] || nb != 1 || off0 != 1 || l0 !== 1'b1 || tmo) begin
            bad++;
            $display("FAIL subword_load%0d: got d=%h beats=%0d off=%0d last=%b want d=%h beats=1 off=1 last=1",
                     i, rd0, nb, off0, l0, exs[i]);
         end
      end
   endtask

   task automatic test_subword_stores();
      sel = 0;
      preload(0, 1, 32'h1122_3344);
      do_access(1'b0, 2'b00, 1'b0, 9'd5, 64'hAB, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      total++;
      if (nb != 1 || off0 != 1 || rd0 !== 32'h0 || l0 !== 1'b1 || m0 !== 1'b0) begin
         bad++; $display("FAIL byte_store_ack: got beats=%0d off=%0d d=%h last=%b want 1 1 0 1", nb, off0, rd0, l0);
      end
      do_access(1'b1, 2'b10, 1'b0, 9'd4, 64'h0, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      total++;
      if (rd0 !== 32'h11AB_3344) begin
         bad++; $display("FAIL byte_store_readback: got %h want 11ab3344", rd0);
      end
      do_access(1'b0, 2'b01, 1'b0, 9'd6, 64'hBEEF, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      do_access(1'b1, 2'b10, 1'b0, 9'd4, 64'h0, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      total++;
      if (rd0 !== 32'h11AB_BEEF) begin
         bad++; $display("FAIL half_store_readback: got %h want 11abbeef", rd0);
      end
      model_store(0, 2'b00, 5, 64'hAB);
      model_store(0, 2'b01, 6, 64'hBEEF);
   endtask

   task automatic test_dword();
      sel = 1;
      preload(1, 2, 32'hAAAA_0001);
      preload(1, 3, 32'hBBBB_0002);
      do_access(1'b1, 2'b11, 1'b0, 9'd8, 64'h0, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      total++;
      if (nb != 2 || off0 != 3 || off1 != 4 || rd0 !== 32'hAAAA_0001 || rd1 !== 32'hBBBB_0002 ||
          l0 !== 1'b0 || l1 !== 1'b1) begin
         bad++;
         $display("FAIL dword_load: got beats=%0d off=%0d/%0d d=%h/%h last=%b/%b want 2 3/4 aaaa0001/bbbb0002 0/1",
                  nb, off0, off1, rd0, rd1, l0, l1);
      end
      total++;
      if (rdy_ok !== 1'b1) begin
         bad++; $display("FAIL dword_load_ready: got ok=%b want 1", rdy_ok);
      end
      do_access(1'b0, 2'b11, 1'b0, 9'd16, 64'h0123_4567_89AB_CDEF, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      total++;
      if (nb != 1 || off0 != 3 || rd0 !== 32'h0 || l0 !== 1'b1 || rdy_ok !== 1'b1) begin
         bad++; $display("FAIL dword_store_ack: got beats=%0d off=%0d d=%h last=%b rdy=%b want 1 3 0 1 1",
                         nb, off0, rd0, l0, rdy_ok);
      end
      model_store(1, 2'b11, 16, 64'h0123_4567_89AB_CDEF);
      do_access(1'b1, 2'b10, 1'b0, 9'd16, 64'h0, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      total++;
      if (rd0 !== 32'h0123_4567) begin
         bad++; $display("FAIL dword_store_w4: got %h want 01234567", rd0);
      end
      do_access(1'b1, 2'b10, 1'b0, 9'd20, 64'h0, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      total++;
      if (rd0 !== 32'h89AB_CDEF) begin
         bad++; $display("FAIL dword_store_w5: got %h want 89abcdef", rd0);
      end
      sel = 0;
      do_access(1'b0, 2'b11, 1'b0, 9'd504, 64'hCAFE_F00D_1357_9BDF, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      model_store(0, 2'b11, 504, 64'hCAFE_F00D_1357_9BDF);
      do_access(1'b1, 2'b11, 1'b0, 9'd504, 64'h0, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      total++;
      if (nb != 2 || rd0 !== mword(0, 504) || rd1 !== mword(0, 508) || off1 != 2) begin
         bad++; $display("FAIL dword_top: got beats=%0d d=%h/%h off1=%0d want 2 %h/%h 2",
                         nb, rd0, rd1, off1, mword(0, 504), mword(0, 508));
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] w1b, w2b;
      sel = 1;
      do_access(1'b1, 2'b10, 1'b0, 9'd6, 64'h0, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      total++;
      if (nb != 1 || off0 != 1 || m0 !== 1'b1 || rd0 !== 32'h0 || l0 !== 1'b1 || rdy_ok !== 1'b1) begin
         bad++; $display("FAIL misaligned_word_load: got beats=%0d off=%0d mis=%b d=%h last=%b want 1 1 1 0 1",
                         nb, off0, m0, rd0, l0);
      end
      do_access(1'b0, 2'b01, 1'b0, 9'd9, 64'h5A5A, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      total++;
      if (nb != 1 || off0 != 1 || m0 !== 1'b1 || rd0 !== 32'h0 || l0 !== 1'b1) begin
         bad++; $display("FAIL misaligned_half_store: got beats=%0d off=%0d mis=%b d=%h last=%b want 1 1 1 0 1",
                         nb, off0, m0, rd0, l0);
      end
      w1b = mword(1, 4);
      w2b = mword(1, 8);
      do_access(1'b1, 2'b11, 1'b0, 9'd8, 64'h0, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      total++;
      if (rd0 !== w2b) begin
         bad++; $display("FAIL misaligned_no_write: got %h want %h", rd0, w2b);
      end
      do_access(1'b1, 2'b10, 1'b0, 9'd4, 64'h0, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      total++;
      if (rd0 !== w1b) begin
         bad++; $display("FAIL misaligned_neighbour: got %h want %h", rd0, w1b);
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      sel = 2;
      preload(2, 0, 32'h1357_2468);
      seen = 0;
      @(negedge clk);
      read_write = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 9'd0; wdata = 64'hDEAD_BEEF;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      if (resp_valid) seen = 1;
      @(negedge clk);
      if (resp_valid) seen = 1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL reset_mid_ready: got %b want 1", req_ready);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (resp_valid) seen = 1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL reset_mid_no_resp: got resp seen=%b want 0", seen);
      end
      do_access(1'b1, 2'b10, 1'b0, 9'd0, 64'h0, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
      total++;
      if (rd0 !== 32'h1357_2468 || off0 != 4) begin
         bad++; $display("FAIL reset_mid_no_commit: got d=%h off=%0d want 13572468 4", rd0, off0);
      end
   endtask

   task automatic test_random();
      logic        rw, sx, mis;
      logic [1:0]  sz;
      int          a, lat, e_nb, e_off0;
      logic [31:0] e_rd0, e_rd1;
      logic [63:0] wd;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         lat = lat_of(s);
         for (int n = 0; n < 50; n++) begin
            rw = 1'($urandom);
            sz = 2'($urandom);
            sx = 1'($urandom);
            a  = $urandom_range(0, 511);
            if ($urandom_range(0, 3) != 0) a = a & ~(nbytes(sz) - 1);
            wd = {$urandom, $urandom};
            mis = (a % nbytes(sz)) != 0;
            e_rd1 = '0;
            if (mis) begin
               e_nb = 1; e_off0 = 1; e_rd0 = '0;
            end else if (rw) begin
               e_nb = (sz == 2'b11) ? 2 : 1;
               e_off0 = lat;
               e_rd0 = exp_load(s, sz, sx, a);
               if (sz == 2'b11) e_rd1 = mword(s, a + 4);
            end else begin
               e_nb = 1; e_off0 = lat; e_rd0 = '0;
            end
            do_access(rw, sz, sx, 9'(a), wd, nb, off0, off1, rd0, rd1, l0, l1, m0, rdy_ok, tmo);
            total++;
            if (nb != e_nb || off0 != e_off0 || m0 !== mis || tmo || rdy_ok !== 1'b1) begin
               bad++;
               $display("FAIL rand_timing inst%0d #%0d: got beats=%0d off=%0d mis=%b tmo=%b rdy=%b want %0d %0d %b 0 1",
                        s, n, nb, off0, m0, tmo, rdy_ok, e_nb, e_off0, mis);
            end
            total++;
            if (rd0 !== e_rd0 || (e_nb == 2 && (rd1 !== e_rd1 || off1 != lat + 1 || l0 !== 1'b0 || l1 !== 1'b1))) begin
               bad++;
               $display("FAIL rand_data inst%0d #%0d rw=%b sz=%0d a=%0d: got %h/%h want %h/%h",
                        s, n, rw, sz, a, rd0, rd1, e_rd0, e_rd1);
            end
            if (!mis && !rw) model_store(s, sz, a, wd);
         end
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = 1'b0; read_write = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = '0; wdata = '0;
      reset = 1'b1;
      for (int s = 0; s < 3; s++)
         for (int w = 0; w < 128; w++) preload(s, w, $urandom);
      test_reset();
      test_subword_loads();
      test_subword_stores();
      test_dword();
      test_misaligned();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sparc_data_ram.md
Name: sparc_data_ram

Overview:
Parametrised successor to the 128x32 enable/read-write RAM: a synchronous, byte-addressed, big-endian data memory for the SPARC datapath. It supports the SPARC load/store sizes byte, halfword, word and doubleword, with sign or zero extension on loads. It uses a valid/ready request handshake with configurable access latency and reports misaligned accesses. It sits between the MEM stage and the data store, and the testbench preloads it hierarchically.

Parameters:
ADDR_WIDTH, 9, byte-address width; DEPTH = 2**(ADDR_WIDTH-2) words (default 128x32).
LATENCY, 1, cycles from request acceptance to first response beat; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request; combinational = (state==IDLE) && !reset.
read_write  in  1  1 = load, 0 = store (same sense as ReadWrite).
size  in  2  00 byte, 01 half, 10 word, 11 doubleword.
sign_ext  in  1  1 = sign-extend byte/half loads; ignored otherwise.
addr  in  ADDR_WIDTH  byte address.
wdata  in  64  store data; byte uses [7:0], half [15:0], word [31:0], dword [63:32] to addr and [31:0] to addr+4.
resp_valid  out  1  one-cycle response beat.
resp_last  out  1  final beat of a response.
rdata  out  32  load data; 0 on store acks and errors.
misaligned  out  1  qualifies resp_valid; access rejected.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Storage is reg [31:0] Mem[0:DEPTH-1], word index = addr[ADDR_WIDTH-1:2]. It is hierarchically accessible for preload and is not cleared by reset.
- Byte lanes are big-endian: offset 0 = Mem[w][31:24], offset 3 = [7:0]. Halfword offset 0 = [31:16], offset 2 = [15:0].
- Reset: state=IDLE, resp_valid=0, resp_last=0, rdata=0, misaligned=0, latency counter=0.
- Acceptance edge E0 is the edge where req_valid && req_ready is sampled high. All request fields are captured at E0; inputs are don't-care afterwards.
- Alignment rules: half requires addr[0]=0, word requires addr[1:0]=0, dword requires addr[2:0]=0. Byte accesses are always aligned.
- Misaligned request: in the cycle after E0, resp_valid=1, resp_last=1, misaligned=1, rdata=0. No memory write occurs. LATENCY is ignored.
- FSM states: IDLE, WAIT, BEAT1, BEAT2, ERR.
  - IDLE -> WAIT at an aligned E0; counter loaded with LATENCY-1.
  - WAIT decrements the counter each cycle. At 0 it goes to BEAT1 (LATENCY=1 passes straight through, so BEAT1 is the cycle after E0).
  - BEAT1 is the cycle E0+LATENCY; resp_valid=1.
  - BEAT1 -> BEAT2 for a dword load; otherwise BEAT1 -> IDLE with resp_last=1 in BEAT1.
  - BEAT2: resp_valid=1, resp_last=1, rdata=Mem[w+1]; then -> IDLE.
  - IDLE -> ERR at a misaligned E0; ERR -> IDLE.
- Load data in BEAT1:
  - byte/half: the selected lane, zero- or sign-extended to 32 bits.
  - word: Mem[w].
  - dword: Mem[w] in BEAT1, Mem[w+1] in BEAT2.
- Stores: committed at the edge ending BEAT1. Byte/half stores modify only their lanes; other lanes are unchanged. Dword stores write Mem[w] and Mem[w+1] at that same edge. The BEAT1 ack has rdata=0, resp_last=1.
- A store followed by a load to the same address returns the new data.
- req_ready is 0 from the cycle after E0 through the final beat. It returns to 1 the cycle after the final beat.
- Throughput: one access per LATENCY+1 cycles; LATENCY+2 for a dword load.
- A dword at the top aligned address uses w+1 ≤ DEPTH-1, so it never wraps.
- Reset mid-operation: returns to IDLE next edge and drops any pending response. A store is not committed unless its BEAT1 edge completes with reset low. If reset is high at that edge, the store is not committed.
- resp_valid is never asserted without a preceding acceptance.

Test Plan:
- Preload Mem[0]=32'h801234F6, LATENCY=1. Loads and their required rdata, each one cycle after acceptance:
  - byte, signed, addr 3 -> 32'hFFFFFFF6
  - byte, unsigned, addr 1 -> 32'h00000012
  - half, signed, addr 0 -> 32'hFFFF8012
  - half, signed, addr 2 -> 32'h000034F6
- Mem[1]=32'h11223344. Store byte wdata=8'hAB at addr 5, then word load at addr 4 -> 32'h11AB3344. Store half 16'hBEEF at addr 6, then word load -> 32'h11ABBEEF.
- LATENCY=3, Mem[2]=32'hAAAA0001, Mem[3]=32'hBBBB0002. Dword load at addr 8 accepted at cycle 10:
  - cycle 13: resp_valid, rdata=AAAA0001, resp_last=0.
  - cycle 14: rdata=BBBB0002, resp_last=1.
  - req_ready low in cycles 11-14, high at cycle 15.
- Dword store at addr 16 with wdata=64'h01234567_89ABCDEF -> Mem[4]=01234567, Mem[5]=89ABCDEF, single ack beat.
- Word load at addr 6, then half store at addr 9:
  - each gives misaligned=1, rdata=0, resp_last=1, one cycle after acceptance, even with LATENCY=3.
  - Mem unchanged.
- LATENCY=4: word store 32'hDEADBEEF at addr 0, reset asserted for 1 cycle two cycles after acceptance.
  - No resp_valid; Mem[0] keeps its old value.
  - req_ready=1 the cycle after reset deasserts.
